vector_data_memory: RTL and testbench

Parametrised data memory for the vectorial ASIP platform. It replaces the single-word, always-ready data RAM with a handshaked memory that serves single-word or LANES-word vector loads and stores, and flags misaligned and out-of-range accesses. It sits between the processor's load/store path and the platform top. An optional sequential dump port replaces the full-width memory export bus.

---
 rtl/vector_data_memory.sv | 143 ++++++++++++++
 tb/tb_vector_data_memory.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_data_memory.sv
// vector_data_memory: handshaked word/vector data RAM with range checks; define DUMP_PORT_EN for the sequential dump port
module vector_data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LANES  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic                    req_vec_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [LANES*DATA_W-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [LANES*DATA_W-1:0] rsp_rdata_o
`ifdef DUMP_PORT_EN
  ,
  input  logic                       dump_start_i,
  output logic                       dump_busy_o,
  output logic                       dump_valid_o,
  output logic [$clog2(DEPTH)-1:0]   dump_addr_o,
  output logic [DATA_W-1:0]          dump_data_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
`ifdef DUMP_PORT_EN
  typedef enum logic [1:0] {IDLE, XFER, RESP, DUMP} state_e;
`else
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
`endif
  state_e state_q, state_d;
  logic we_q, vec_q, err_q;
  logic [AW-1:0] base_q, idx;
  logic [LW-1:0] beat_q;
  logic [LANES-1:0][DATA_W-1:0] wdata_q, acc_q, acc_d, rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W:0] end_w;
  logic dstart, accept, bad, last;
`ifdef DUMP_PORT_EN
  logic [AW-1:0] dptr_q, daddr_q;
  logic dvalid_q;
  logic [DATA_W-1:0] ddata_q;
  assign dstart = dump_start_i;
  assign dump_busy_o = state_q == DUMP;
  assign dump_valid_o = dvalid_q;
  assign dump_addr_o = daddr_q;
  assign dump_data_o = ddata_q;
`else
  assign dstart = 1'b0;
`endif
  assign req_ready_o = rst_ni && state_q == IDLE && !dstart;
  assign accept = req_valid_i && req_ready_o;
  // end word index is one bit wider than the address so a huge base cannot wrap into range
  assign end_w = (ADDR_W+1)'(req_addr_i[ADDR_W-1:2]) + (req_vec_i ? (ADDR_W+1)'(LANES) : (ADDR_W+1)'(1));
  assign bad = (|req_addr_i[1:0]) || end_w > (ADDR_W+1)'(DEPTH);
  assign last = !vec_q || beat_q == LW'(LANES-1);
  assign idx = base_q + AW'(beat_q);
  assign rd_word = mem_q[idx];
  assign rsp_valid_o = state_q == RESP;
  assign rsp_err_o = state_q == RESP && err_q;
  assign rsp_rdata_o = rdata_q;
  // next state: accept/reject in IDLE, beat through XFER, single-cycle RESP, optional sweep
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = accept ? (bad ? RESP : XFER) : IDLE;
      XFER: state_d = last ? RESP : XFER;
      RESP: state_d = IDLE;
`ifdef DUMP_PORT_EN
      DUMP: state_d = dptr_q == AW'(DEPTH-1) ? IDLE : DUMP;
`endif
      default: state_d = IDLE;
    endcase
`ifdef DUMP_PORT_EN
    if (state_q == IDLE && dump_start_i) state_d = DUMP;
`endif
  end
  // load accumulator including the beat being read this cycle, so the last lane reaches rdata_q on time
  always_comb begin
    acc_d = acc_q;
    if (state_q == XFER && !we_q) acc_d[beat_q] = rd_word;
  end
  // request capture, beat counter and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      vec_q   <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        vec_q   <= req_vec_i;
        err_q   <= bad;
        base_q  <= AW'(req_addr_i[ADDR_W-1:2]);
        beat_q  <= '0;
        wdata_q <= req_wdata_i;
        acc_q   <= '0;
      end
      if (state_q == XFER) begin
        beat_q <= beat_q + LW'(1);
        acc_q  <= acc_d;
      end
      if (state_q == XFER && state_d == RESP) rdata_q <= acc_d;
      else if (accept && bad) rdata_q <= '0;
    end
  end
  // storage array is not reset; a store beat writes one word
  always_ff @(posedge clk_i) begin
    if (state_q == XFER && we_q) mem_q[idx] <= wdata_q[beat_q];
  end
`ifdef DUMP_PORT_EN
  // sweep pointer and registered dump outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dptr_q   <= '0;
      daddr_q  <= '0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
    end else begin
      dvalid_q <= state_q == DUMP;
      if (state_q == DUMP) begin
        dptr_q  <= dptr_q + AW'(1);
        daddr_q <= dptr_q;
        ddata_q <= mem_q[dptr_q];
      end else begin
        dptr_q <= '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_vector_data_memory.sv
// tb_vector_data_memory: randomized self-checking bench against a word-array model
module tb_vector_data_memory;
  localparam int DW = 32, AW = 32, DEPTH = 1024, LANES = 8;
  localparam int XW = $clog2(DEPTH), VW = LANES * DW;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_vec = 0;
  logic [AW-1:0] req_addr = '0;
  logic [VW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [VW-1:0] rsp_rdata;
`ifdef DUMP_PORT_EN
  logic dump_start = 0, dump_busy, dump_valid;
  logic [XW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
`endif
  logic [DW-1:0] mdl [DEPTH];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  vector_data_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_vec_i(req_vec), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata)
`ifdef DUMP_PORT_EN
    , .dump_start_i(dump_start), .dump_busy_o(dump_busy), .dump_valid_o(dump_valid),
    .dump_addr_o(dump_addr), .dump_data_o(dump_data)
`endif
  );

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  // reference: word array, range rule on plain integers, expected edges until response
  task automatic model(input logic we, input logic vec, input logic [AW-1:0] addr, input logic [VW-1:0] wd,
                       output logic [VW-1:0] rd, output logic er, output int n);
    longint unsigned base;
    int cnt;
    base = longint'(addr) / 4;
    cnt = vec ? LANES : 1;
    er = (addr % 4 != 0) || (base + cnt > DEPTH);
    rd = '0;
    n = er ? 1 : cnt + 1;
    if (!er)
      for (int k = 0; k < cnt; k++)
        if (we) mdl[base + k] = wd[k*DW +: DW];
        else rd[k*DW +: DW] = mdl[base + k];
  endtask

  // drive one request from a negedge; report data, error, negedges to rsp_valid, and single-pulse flag
  task automatic xact(input logic we, input logic vec, input logic [AW-1:0] addr, input logic [VW-1:0] wd,
                      output logic [VW-1:0] rd, output logic er, output int n, output logic once);
    int t;
    t = 0;
    req_we = we; req_vec = vec; req_addr = addr; req_wdata = wd; req_valid = 1;
    #1;
    while (!req_ready && t < 100) begin @(negedge clk); #1; t++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    once = !rsp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want all 0", rsp_valid, rsp_err, rsp_rdata);
    end
`ifdef DUMP_PORT_EN
    checks++;
    if ({dump_busy, dump_valid, dump_addr, dump_data} !== '0) begin
      errors++; $display("FAIL reset_dump: busy=%b valid=%b addr=%h data=%h want all 0", dump_busy, dump_valid, dump_addr, dump_data);
    end
`endif
    rst_n = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
  endtask

  task automatic test_fill();
    logic [VW-1:0] wd, ord, erd;
    logic oer, eer, one;
    int on, en;
    for (int b = 0; b < DEPTH / LANES; b++) begin
      wd = rnd_vec();
      xact(1, 1, AW'(b * LANES * 4), wd, ord, oer, on, one);
      model(1, 1, AW'(b * LANES * 4), wd, erd, eer, en);
      checks++;
      if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
        errors++; $display("FAIL fill[%0d]: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", b, oer, one, on, ord, eer, en, erd);
      end
    end
  endtask

  task automatic test_single();
    logic [VW-1:0] ord, erd, wd;
    logic oer, eer, one;
    int on, en;
    wd = '0;
    wd[DW-1:0] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      xact(i == 0, 0, 32'h10, wd, ord, oer, on, one);
      model(i == 0, 0, 32'h10, wd, erd, eer, en);
      checks++;
      if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
        errors++; $display("FAIL single[%0d]: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", i, oer, one, on, ord, eer, en, erd);
      end
    end
    checks++;
    if (ord[DW-1:0] !== 32'hDEADBEEF || ord[VW-1:DW] !== '0) begin
      errors++; $display("FAIL single_const: rdata=%h want lane0=deadbeef others 0", ord);
    end
  endtask

  task automatic test_vector();
    logic [VW-1:0] ord, erd, wd;
    logic oer, eer, one;
    int on, en;
    for (int k = 0; k < LANES; k++) wd[k*DW +: DW] = DW'(32'h100 + k);
    for (int i = 0; i < 3; i++) begin
      xact(i == 0, i < 2, i < 2 ? 32'h40 : 32'h4C, wd, ord, oer, on, one);
      model(i == 0, i < 2, i < 2 ? 32'h40 : 32'h4C, wd, erd, eer, en);
      checks++;
      if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
        errors++; $display("FAIL vector[%0d]: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", i, oer, one, on, ord, eer, en, erd);
      end
    end
    checks++;
    if (ord[DW-1:0] !== 32'h103) begin errors++; $display("FAIL vector_4c: got %h want 00000103", ord[DW-1:0]); end
  endtask

  task automatic test_errors();
    logic [AW-1:0] addrs [10] = '{32'h42, 32'h42, 32'h43, 4*(DEPTH-4), 4*DEPTH, 32'hFFFF_FFE0,
                                  4*(DEPTH-8), 4*(DEPTH-1), 32'h40, 4*(DEPTH-8)};
    logic [9:0] wes  = 10'b00_0011_1011;
    logic [9:0] vecs = 10'b11_0110_1011;
    logic [VW-1:0] ord, erd, wd;
    logic oer, eer, one;
    int on, en;
    for (int i = 0; i < 10; i++) begin
      wd = rnd_vec();
      xact(wes[i], vecs[i], addrs[i], wd, ord, oer, on, one);
      model(wes[i], vecs[i], addrs[i], wd, erd, eer, en);
      checks++;
      if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
        errors++; $display("FAIL errcase[%0d] addr=%h: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", i, addrs[i], oer, one, on, ord, eer, en, erd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] wd, erd;
    logic eer, stall_bad;
    int en, n;
    wd = rnd_vec();
    req_we = 1; req_vec = 1; req_addr = 32'h100; req_wdata = wd; req_valid = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b want 1", req_ready); end
    model(1, 1, 32'h100, wd, erd, eer, en);
    @(posedge clk);
    @(negedge clk);
    req_we = 0; req_vec = 0; req_addr = 32'h104; req_wdata = rnd_vec();
    stall_bad = 0;
    for (int i = 1; i <= LANES + 1; i++) begin
      #1;
      if (req_ready !== 1'b0 || rsp_valid !== (i == LANES + 1)) stall_bad = 1;
      @(negedge clk);
    end
    checks++;
    if (stall_bad !== 1'b0) begin errors++; $display("FAIL b2b_stall: ready/valid pattern wrong during XFER/RESP, got flag %b want 0", stall_bad); end
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b want 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    model(0, 0, 32'h104, '0, erd, eer, en);
    checks++;
    if ({rsp_err, n, rsp_rdata} !== {eer, en, erd}) begin
      errors++; $display("FAIL b2b_load: err=%b lat=%0d rdata=%h want err=%b lat=%0d rdata=%h", rsp_err, n, rsp_rdata, eer, en, erd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] wd, ord, erd;
    logic oer, eer, one, pulse;
    int on, en;
    wd = rnd_vec();
    req_we = 1; req_vec = 1; req_addr = 32'h80; req_wdata = wd; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL midreset_idle: ready=%b valid=%b want 0 0", req_ready, rsp_valid); end
    pulse = 0;
    repeat (2) begin @(negedge clk); pulse |= rsp_valid; end
    rst_n = 1;
    repeat (4) begin @(negedge clk); pulse |= rsp_valid; end
    checks++;
    if (pulse !== 1'b0) begin errors++; $display("FAIL midreset_pulse: rsp_valid seen=%b want 0", pulse); end
    for (int k = 0; k < 3; k++) mdl[32 + k] = wd[k*DW +: DW];
    xact(0, 1, 32'h80, '0, ord, oer, on, one);
    model(0, 1, 32'h80, '0, erd, eer, en);
    checks++;
    if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
      errors++; $display("FAIL midreset_load: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", oer, one, on, ord, eer, en, erd);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] wd, ord, erd;
    logic [AW-1:0] addr;
    logic oer, eer, one, we, vec;
    int on, en, r;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom); vec = 1'($urandom); wd = rnd_vec();
      r = $urandom_range(0, 15);
      addr = AW'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 0) addr = $urandom;
      else if (r < 3) addr = addr | AW'($urandom_range(1, 3));
      xact(we, vec, addr, wd, ord, oer, on, one);
      model(we, vec, addr, wd, erd, eer, en);
      checks++;
      if ({oer, one, on, ord} !== {eer, 1'b1, en, erd}) begin
        errors++; $display("FAIL random[%0d] we=%b vec=%b addr=%h: err=%b once=%b lat=%0d rdata=%h want err=%b once=1 lat=%0d rdata=%h", i, we, vec, addr, oer, one, on, ord, eer, en, erd);
      end
    end
  endtask

`ifdef DUMP_PORT_EN
  task automatic test_dump();
    logic [VW-1:0] erd;
    logic eer;
    int idx, t, bad, stall, n, en;
    dump_start = 1; req_we = 0; req_vec = 0; req_addr = 32'h10; req_valid = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL dump_wins: req_ready=%b want 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    dump_start = 0;
    checks++;
    if (dump_busy !== 1'b1) begin errors++; $display("FAIL dump_busy: got %b want 1", dump_busy); end
    idx = 0; t = 0; bad = 0; stall = 0;
    while (1) begin
      if (dump_busy && req_ready) stall++;
      if (dump_valid) begin
        if (dump_addr !== XW'(idx) || dump_data !== mdl[idx]) begin
          if (bad == 0) $display("FAIL dump_beat[%0d]: addr=%h data=%h want addr=%h data=%h", idx, dump_addr, dump_data, XW'(idx), mdl[idx]);
          bad++;
        end
        idx++;
      end
      if (idx == DEPTH || t > DEPTH + 20) break;
      @(negedge clk);
      t++;
    end
    checks++;
    if (idx !== DEPTH) begin errors++; $display("FAIL dump_count: got %0d beats want %0d", idx, DEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dump_data: %0d bad beats want 0", bad); end
    checks++;
    if (stall !== 0) begin errors++; $display("FAIL dump_stall: ready high in %0d busy cycles want 0", stall); end
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL dump_after_ready: got %b want 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    model(0, 0, 32'h10, '0, erd, eer, en);
    checks++;
    if ({rsp_err, n, rsp_rdata} !== {eer, en, erd}) begin
      errors++; $display("FAIL dump_then_load: err=%b lat=%0d rdata=%h want err=%b lat=%0d rdata=%h", rsp_err, n, rsp_rdata, eer, en, erd);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_vector();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DUMP_PORT_EN
    test_dump();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
